// File: rtl/prng_seed_arbiter.sv
// prng_seed_arbiter: round-robin scheduler that shares one PRNG among NUM_REQ
// requesters. It grants one requester, strobes its seed into the PRNG, routes
// OUT_PER_SEED output words back to that requester and then pulses done.
//
// Ports
//   clk1, rst_n      : clock (rising edge) and asynchronous active-low reset
//   req              : per-requester seed request (level, held until done)
//   req_seed         : packed seeds, requester i in bits [32i+31:32i]
//   grant            : one-hot owner of the PRNG, zero when idle
//   prng_in_valid    : one-cycle seed strobe to the PRNG
//   prng_seed        : seed latched from the granted requester
//   prng_out_valid   : PRNG output strobe
//   prng_rand_num    : PRNG output word
//   rsp_valid        : per-requester data strobe (subset of grant)
//   rsp_data         : registered copy of prng_rand_num, shared bus
//   done             : one-cycle completion pulse for the granted requester
//   timeout_err      : pulses with done when the PRNG went quiet too long
module prng_seed_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned OUT_PER_SEED = 256,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_seed,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    prng_in_valid,
  output logic [31:0]             prng_seed,
  input  logic                    prng_out_valid,
  input  logic [31:0]             prng_rand_num,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [NUM_REQ-1:0]      done,
  output logic                    timeout_err
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(OUT_PER_SEED + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;

  logic [NUM_REQ-1:0]  grant_d, rsp_valid_d, done_d;
  logic                in_valid_d, timeout_err_d;
  logic [31:0]         seed_d, rsp_data_d;

  logic [PTR_W-1:0]    sel_idx;
  logic                sel_found;
  logic [31:0]         cand;
  logic [31:0]         sel_seed;
  logic [NUM_REQ-1:0]  sel_onehot;
  logic                last_word;
  logic                idle_expire;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!sel_found && req[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Seed mux and one-hot decode of the selected requester.
  always_comb begin
    sel_seed   = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) begin
        sel_seed      = req_seed[32*i +: 32];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // A word in flight always beats the idle limit on the same cycle.
  assign last_word   = prng_out_valid && (words_q == CNT_W'(OUT_PER_SEED - 1));
  assign idle_expire = !prng_out_valid && (idle_q == IDLE_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sel_found) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_COLLECT;
      S_COLLECT: if (last_word || idle_expire) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything is registered below.
  always_comb begin
    grant_d       = grant;
    in_valid_d    = 1'b0;
    seed_d        = prng_seed;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data;
    done_d        = '0;
    timeout_err_d = 1'b0;
    words_d       = words_q;
    idle_d        = idle_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d    = sel_onehot;
          seed_d     = sel_seed;
          owner_d    = sel_idx;
          in_valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        words_d = '0;
        idle_d  = '0;
      end
      S_COLLECT: begin
        if (prng_out_valid) begin
          rsp_data_d  = prng_rand_num;
          rsp_valid_d = grant;
          words_d     = words_q + CNT_W'(1);
          idle_d      = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
        // done lands in the same cycle as the last rsp_valid
        if (state_d == S_DONE) begin
          done_d        = grant;
          timeout_err_d = idle_expire;
        end
      end
      S_DONE: begin
        grant_d  = '0;
        rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      grant         <= '0;
      prng_in_valid <= 1'b0;
      prng_seed     <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      done          <= '0;
      timeout_err   <= 1'b0;
      words_q       <= '0;
      idle_q        <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
    end else begin
      grant         <= grant_d;
      prng_in_valid <= in_valid_d;
      prng_seed     <= seed_d;
      rsp_valid     <= rsp_valid_d;
      rsp_data      <= rsp_data_d;
      done          <= done_d;
      timeout_err   <= timeout_err_d;
      words_q       <= words_d;
      idle_q        <= idle_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_prng_seed_arbiter.sv
// Testbench for prng_seed_arbiter: directed scenario sequence with random
// seeds, PRNG words and output gaps, checked against a transaction-level model
// (round-robin pick by arithmetic, expected word stream from the PRNG driver).
module tb_prng_seed_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int OUT_PER_SEED = 256;
  localparam int TIMEOUT      = 1023;

  logic                   clk1;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req;
  logic [32*NUM_REQ-1:0]  req_seed;
  logic [NUM_REQ-1:0]     grant;
  logic                   prng_in_valid;
  logic [31:0]            prng_seed;
  logic                   prng_out_valid;
  logic [31:0]            prng_rand_num;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [31:0]            rsp_data;
  logic [NUM_REQ-1:0]     done;
  logic                   timeout_err;

  prng_seed_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .OUT_PER_SEED (OUT_PER_SEED),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .req            (req),
    .req_seed       (req_seed),
    .grant          (grant),
    .prng_in_valid  (prng_in_valid),
    .prng_seed      (prng_seed),
    .prng_out_valid (prng_out_valid),
    .prng_rand_num  (prng_rand_num),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .done           (done),
    .timeout_err    (timeout_err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rr_ptr_m = 0;
  logic [31:0] seeds [NUM_REQ];

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_seeds();
    for (int i = 0; i < NUM_REQ; i++) req_seed[32*i +: 32] = seeds[i];
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    onehot = NUM_REQ'(1) << g;
  endfunction

  // Model: first set request at or above the pointer, wrapping.
  function automatic int pick(input logic [NUM_REQ-1:0] r);
    int idx;
    pick = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (rr_ptr_m + k) % NUM_REQ;
      if (pick < 0 && r[idx]) pick = idx;
    end
  endfunction

  // One transaction from the IDLE sample of req. n_words < OUT_PER_SEED means
  // the PRNG goes quiet and a timeout is expected. rst_at > 0 asserts reset
  // right after that many words.
  task automatic run_txn(input int n_words, input bit extra_word,
                         input bit drop_req, input int rst_at);
    int          g;
    int          gap;
    int          waited;
    bit          stray;
    logic [31:0] seed_lat;
    logic [31:0] w;
    g        = pick(req);
    seed_lat = seeds[g];
    tick();
    chk("grant", 32'(grant), 32'(onehot(g)));
    chk("in_valid_issue", 32'(prng_in_valid), 32'd1);
    chk("seed", prng_seed, seed_lat);
    // seed churn after the sample, optional req drop, stray output in ISSUE
    for (int i = 0; i < NUM_REQ; i++) seeds[i] = $urandom;
    drive_seeds();
    if (drop_req) req[g] = 1'b0;
    prng_out_valid = 1'($urandom_range(0, 1));
    prng_rand_num  = $urandom;
    tick();
    prng_out_valid = 1'b0;
    chk("in_valid_pulse", 32'(prng_in_valid), 32'd0);
    chk("rsp_in_issue", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < n_words; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        tick();
        chk("rsp_gap", 32'(rsp_valid), 32'd0);
      end
      w              = $urandom;
      prng_out_valid = 1'b1;
      prng_rand_num  = w;
      tick();
      prng_out_valid = 1'b0;
      chk("rsp_valid", 32'(rsp_valid), 32'(onehot(g)));
      chk("rsp_data", rsp_data, w);
      chk("done", 32'(done), (k == OUT_PER_SEED - 1) ? 32'(onehot(g)) : 32'd0);
      chk("timeout_err_low", 32'(timeout_err), 32'd0);
      if (k == rst_at - 1) begin
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_in_valid", 32'(prng_in_valid), 32'd0);
        chk("rst_seed", prng_seed, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        prng_out_valid = 1'b1;
        repeat (2) tick();
        prng_out_valid = 1'b0;
        chk("rst_no_done", 32'(done), 32'd0);
        @(negedge clk1);
        rst_n    = 1'b1;
        rr_ptr_m = 0;
        return;
      end
    end
    if (n_words < OUT_PER_SEED) begin
      waited = 0;
      stray  = 1'b0;
      while (done == '0 && waited < 2 * TIMEOUT) begin
        tick();
        waited++;
        if (rsp_valid != '0) stray = 1'b1;
      end
      chk("timeout_latency", 32'(waited), 32'(TIMEOUT));
      chk("timeout_done", 32'(done), 32'(onehot(g)));
      chk("timeout_err", 32'(timeout_err), 32'd1);
      chk("timeout_no_rsp", 32'(stray), 32'd0);
    end
    if (extra_word) begin
      prng_out_valid = 1'b1;
      prng_rand_num  = $urandom;
    end
    rr_ptr_m = (g + 1) % NUM_REQ;
    tick();
    prng_out_valid = 1'b0;
    chk("grant_release", 32'(grant), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("rsp_after_done", 32'(rsp_valid), 32'd0);
    chk("timeout_err_one_cycle", 32'(timeout_err), 32'd0);
    chk("seed_hold", prng_seed, seed_lat);
  endtask

  initial begin
    rst_n          = 1'b0;
    req            = '0;
    prng_out_valid = 1'b0;
    prng_rand_num  = '0;
    for (int i = 0; i < NUM_REQ; i++) seeds[i] = $urandom;
    drive_seeds();
    #12;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_in_valid", 32'(prng_in_valid), 32'd0);
    chk("reset_seed", prng_seed, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;

    // Round-robin with every request held: 0,1,2,3.
    req = '1;
    repeat (NUM_REQ) run_txn(OUT_PER_SEED, 1'b0, 1'b0, 0);

    // Pointer wrap after the grant to 3: expect 0 then 2.
    req = 4'b0101;
    repeat (2) run_txn(OUT_PER_SEED, 1'b0, 1'b0, 0);

    // Single request with a known seed and a 257th word.
    req      = 4'b0001;
    seeds[0] = 32'h1234_5678;
    drive_seeds();
    run_txn(OUT_PER_SEED, 1'b1, 1'b0, 0);

    // Stray PRNG outputs while idle.
    req = '0;
    repeat (3) begin
      prng_out_valid = 1'b1;
      prng_rand_num  = $urandom;
      tick();
      chk("idle_rsp", 32'(rsp_valid), 32'd0);
      chk("idle_grant", 32'(grant), 32'd0);
    end
    prng_out_valid = 1'b0;

    // Reset after 100 words, then re-request with every bit set.
    req = 4'b0100;
    run_txn(OUT_PER_SEED, 1'b0, 1'b0, 100);
    req = '1;
    run_txn(OUT_PER_SEED, 1'b0, 1'b1, 0);

    // PRNG stops after 10 words.
    req = '0;
    req[NUM_REQ-1] = 1'b1;
    run_txn(10, 1'b0, 1'b0, 0);

    req = '0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prng_seed_arbiter.md
# prng_seed_arbiter

Single-clock scheduler that shares one `prng` instance among `NUM_REQ` requesters. It takes seed requests, grants the PRNG to one requester at a time in round-robin order, and issues a one-cycle seed pulse. It then routes the resulting `OUT_PER_SEED` random numbers back to the granted requester and signals completion. It sits on the `clk1` side, between the requester blocks and the PRNG's `in_valid`/`seed`/`out_valid`/`rand_num` ports.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `OUT_PER_SEED`, 256: `rand_num` words expected per seed.
- `TIMEOUT`, 1023: max idle cycles between PRNG outputs while collecting.

- `clk1`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester seed request; level, held until matching `done`.
- `req_seed`  in  32*NUM_REQ  seed of requester i in bits [32i+31:32i].
- `grant`  out  NUM_REQ  one-hot owner of the PRNG; all-zero when idle.
- `prng_in_valid`  out  1  one-cycle seed strobe to the PRNG.
- `prng_seed`  out  32  latched seed of the granted requester.
- `prng_out_valid`  in  1  PRNG output strobe.
- `prng_rand_num`  in  32  PRNG output word.
- `rsp_valid`  out  NUM_REQ  per-requester data strobe.
- `rsp_data`  out  32  registered copy of `prng_rand_num`, shared bus.
- `done`  out  NUM_REQ  one-cycle completion pulse for the granted requester.
- `timeout_err`  out  1  one-cycle pulse, coincident with `done`, when a transaction ended by timeout.

## Operation
- States: IDLE, ISSUE, COLLECT, DONE.
- **IDLE**
  - If `req` is nonzero, select the first set bit searching upward (with wrap) from `rr_ptr`.
  - Register `grant`, latch the selected seed into `prng_seed`, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `prng_in_valid`=1 for exactly this cycle.
  - Clear the word counter and the idle counter; go to COLLECT.
- **COLLECT**
  - On each `prng_out_valid`:
    - register `prng_rand_num` into `rsp_data`;
    - assert `rsp_valid[g]` the next cycle;
    - increment the word counter (width clog2(OUT_PER_SEED+1));
    - clear the idle counter.
  - When the counter reaches `OUT_PER_SEED`, go to DONE.
  - Otherwise the idle counter increments each cycle. When it reaches `TIMEOUT`, go to DONE with the timeout flag set.
- **DONE**
  - `done[g]`=1 for one cycle; `timeout_err`=flag.
  - `rr_ptr` ← (g+1) mod NUM_REQ.
  - Clear `grant` on exit; go to IDLE.
- `prng_out_valid` in IDLE, ISSUE or DONE is ignored: no `rsp_valid`, no count.
- `prng_out_valid` arriving after `OUT_PER_SEED` words is ignored.
- Deasserting `req[g]` mid-transaction does not abort it; the transaction runs to DONE.
- `req_seed` changes after the IDLE sample have no effect.
- `prng_seed` holds its value outside ISSUE. `prng_in_valid` is never high outside ISSUE.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0
  - `grant`=0, `prng_in_valid`=0, `prng_seed`=0
  - `rsp_valid`=0, `rsp_data`=0
  - `done`=0, `timeout_err`=0
- Reset mid-transaction returns everything to the reset values immediately; no `done` pulse is produced.
- `req` sampled at edge t → `grant` valid from t+1, `prng_in_valid` high during cycle t+1 to t+2.
- `prng_out_valid` sampled at edge e → `rsp_valid`/`rsp_data` high/valid during cycle e+1 to e+2 (1-cycle latency).
- Last word at edge e → state DONE during cycle e+1; `done` coincides with the last `rsp_valid`.
- Back-to-back requests: DONE → IDLE → grant. One IDLE cycle minimum between transactions.
- `rsp_valid` is always a subset of `grant` (or the final cycle of `grant`). At most one bit of `rsp_valid`/`done` is set.

## Test plan
- **Single request.** `req`=4'b0001, seed 32'h1234_5678, PRNG model returns 256 words.
  - Expect 1 `prng_in_valid` pulse with `prng_seed`=32'h1234_5678.
  - Expect 256 `rsp_valid[0]` pulses carrying the model words in order.
  - Expect `done[0]` coincident with the 256th, and `timeout_err`=0.
- **Round-robin.** `req`=4'b1111 held continuously.
  - Grant order 0,1,2,3,0.
  - Each `done` followed by exactly one IDLE cycle before the next grant.
- **Pointer wrap.** After a grant to 3, `req`=4'b0101 → next grant 0, then 2.
- **Timeout.** PRNG model stops after 10 words.
  - Expect `done[g]` and `timeout_err` high together exactly 1023 cycles after the 10th word.
- **Spurious outputs.**
  - `prng_out_valid` pulsed in IDLE → no `rsp_valid`.
  - 257 words in one transaction → only 256 forwarded.
- **Reset mid-COLLECT.** Assert `rst_n`=0 after 100 words → all outputs 0 within the same cycle. Re-request after release → `grant` to requester 0 (`rr_ptr` reset).
